// File: rtl/alu_seq_pkg.sv
// Shared types for the lane ALU vector sequencer: FSM state encoding,
// ALU outputControl encodings and the bundled ALU control word.
package alu_seq_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD,
        S_EX,
        S_WB,
        S_DONE
    } seq_state_e;

    localparam logic [2:0] ALU_OP_ADDSUB  = 3'b000;
    localparam logic [2:0] ALU_OP_FPADD   = 3'b001;
    localparam logic [2:0] ALU_OP_MUL     = 3'b010;
    localparam logic [2:0] ALU_OP_FPMUL   = 3'b011;
    localparam logic [2:0] ALU_OP_BITWISE = 3'b100;

    typedef struct packed {
        logic [2:0] out_ctrl;
        logic       addsub;
        logic       mux;
        logic [1:0] bitwise;
        logic [1:0] comp;
    } alu_ctrl_t;

endpackage

// File: rtl/alu_seq_idx_counter.sv
// Element index counter for the vector sequencer: synchronous clear,
// increment, and a flag for the last element of the current vector.
module alu_seq_idx_counter #(
    parameter int MAX_VLEN = 32,
    parameter int IDX_W    = $clog2(MAX_VLEN)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             inc,
    input  logic [IDX_W:0]   vlen,
    output logic [IDX_W-1:0] idx,
    output logic             last
);

    logic [IDX_W-1:0] idx_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q <= '0;
        end else if (clr) begin
            idx_q <= '0;
        end else if (inc) begin
            idx_q <= idx_q + IDX_W'(1);
        end
    end

    // Only meaningful while vlen >= 1, which holds whenever an element is in flight.
    assign last = ({1'b0, idx_q} == (vlen - (IDX_W + 1)'(1)));
    assign idx  = idx_q;

endmodule

// File: rtl/alu_vector_sequencer.sv
// Steps one lane's ALU/register-file pair through the elements of a vector
// instruction (RD -> EX -> WB per element). Optional macro: ALU_SEQ_MASK_EN.
module alu_vector_sequencer
    import alu_seq_pkg::*;
#(
    parameter int WIDTH    = 32,
    parameter int MAX_VLEN = 32
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          instr_valid,
    output logic                          instr_ready,
    input  logic [2:0]                    instr_out_ctrl,
    input  logic                          instr_sub,
    input  logic                          instr_use_c,
    input  logic [1:0]                    instr_bitwise,
    input  logic [1:0]                    instr_comp,
    input  logic                          instr_is_cmp,
`ifdef ALU_SEQ_MASK_EN
    input  logic [MAX_VLEN-1:0]           instr_mask,
`endif
    input  logic [$clog2(MAX_VLEN):0]     instr_vlen,
    output logic                          rf_rd_en,
    output logic [$clog2(MAX_VLEN)-1:0]   rf_rd_idx,
    output logic [2:0]                    alu_out_ctrl,
    output logic                          alu_addsub,
    output logic                          alu_mux,
    output logic [1:0]                    alu_bitwise,
    output logic [1:0]                    alu_comp,
    input  logic [WIDTH-1:0]              alu_result,
    input  logic                          alu_pred,
    output logic                          rf_wr_en,
    output logic [$clog2(MAX_VLEN)-1:0]   rf_wr_idx,
    output logic [WIDTH-1:0]              rf_wr_data,
    output logic                          pred_wr_en,
    output logic [$clog2(MAX_VLEN)-1:0]   pred_wr_idx,
    output logic                          pred_wr_bit,
    output logic                          busy,
    output logic                          done
);

    localparam int IDX_W = $clog2(MAX_VLEN);
    localparam logic [IDX_W:0] VLEN_MAX = (IDX_W + 1)'(MAX_VLEN);

    seq_state_e       state_q;
    alu_ctrl_t        ctrl_q;
    logic             is_cmp_q;
    logic [IDX_W:0]   vlen_q;
    logic [WIDTH-1:0] result_q;
    logic             pred_q;
    logic             ready_q;
    logic             busy_q;
    logic             done_q;
    logic             rd_en_q;
    logic             wr_en_q;
    logic             pwr_en_q;

    logic [IDX_W-1:0] idx;
    logic             last;
    logic             elem_en;
    logic [IDX_W:0]   vlen_clamped;

    assign vlen_clamped = (instr_vlen > VLEN_MAX) ? VLEN_MAX : instr_vlen;

    alu_seq_idx_counter #(
        .MAX_VLEN (MAX_VLEN),
        .IDX_W    (IDX_W)
    ) u_idx_counter (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (state_q == S_DONE),
        .inc   ((state_q == S_WB) && !last),
        .vlen  (vlen_q),
        .idx   (idx),
        .last  (last)
    );

`ifdef ALU_SEQ_MASK_EN
    logic [MAX_VLEN-1:0] mask_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mask_q <= '0;
        end else if (state_q == S_IDLE && instr_valid) begin
            mask_q <= instr_mask;
        end
    end

    assign elem_en = mask_q[idx];
`else
    assign elem_en = 1'b1;
`endif

    // NOTE: every output strobe is a register updated on the transition into
    // its state, so the FSM block uses only non-blocking assignments.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            ctrl_q   <= '0;
            is_cmp_q <= 1'b0;
            vlen_q   <= '0;
            result_q <= '0;
            pred_q   <= 1'b0;
            ready_q  <= 1'b1;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            rd_en_q  <= 1'b0;
            wr_en_q  <= 1'b0;
            pwr_en_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (instr_valid) begin
                        ctrl_q   <= '{out_ctrl: instr_out_ctrl, addsub: instr_sub,
                                      mux: instr_use_c, bitwise: instr_bitwise,
                                      comp: instr_comp};
                        is_cmp_q <= instr_is_cmp;
                        vlen_q   <= vlen_clamped;
                        ready_q  <= 1'b0;
                        busy_q   <= 1'b1;
                        if (vlen_clamped == '0) begin
                            state_q <= S_DONE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= S_RD;
                            rd_en_q <= 1'b1;
                        end
                    end
                end
                S_RD: begin
                    rd_en_q <= 1'b0;
                    state_q <= S_EX;
                end
                S_EX: begin
                    // Read data arrived this cycle; capture the ALU output and arm the write.
                    result_q <= alu_result;
                    pred_q   <= alu_pred;
                    wr_en_q  <= !is_cmp_q && elem_en;
                    pwr_en_q <= is_cmp_q && elem_en;
                    state_q  <= S_WB;
                end
                S_WB: begin
                    wr_en_q  <= 1'b0;
                    pwr_en_q <= 1'b0;
                    if (last) begin
                        state_q <= S_DONE;
                        done_q  <= 1'b1;
                    end else begin
                        state_q <= S_RD;
                        rd_en_q <= 1'b1;
                    end
                end
                S_DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    ready_q <= 1'b1;
                    ctrl_q  <= '0;
                    vlen_q  <= '0;
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign instr_ready  = ready_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign rf_rd_en     = rd_en_q;
    assign rf_rd_idx    = idx;
    assign alu_out_ctrl = ctrl_q.out_ctrl;
    assign alu_addsub   = ctrl_q.addsub;
    assign alu_mux      = ctrl_q.mux;
    assign alu_bitwise  = ctrl_q.bitwise;
    assign alu_comp     = ctrl_q.comp;
    assign rf_wr_en     = wr_en_q;
    assign rf_wr_idx    = idx;
    assign rf_wr_data   = result_q;
    assign pred_wr_en   = pwr_en_q;
    assign pred_wr_idx  = idx;
    assign pred_wr_bit  = pred_q;

endmodule

// File: tb/tb_alu_vector_sequencer.sv
// Directed bench for alu_vector_sequencer with a small register-file/ALU model:
// A[k]=k+1, B[k]=10, C[k]=3. Honours ALU_SEQ_MASK_EN when defined.
module tb_alu_vector_sequencer;

    localparam int WIDTH    = 32;
    localparam int MAX_VLEN = 32;
    localparam int IDX_W    = 5;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             instr_valid;
    logic             instr_ready;
    logic [2:0]       instr_out_ctrl;
    logic             instr_sub;
    logic             instr_use_c;
    logic [1:0]       instr_bitwise;
    logic [1:0]       instr_comp;
    logic             instr_is_cmp;
    logic [MAX_VLEN-1:0] instr_mask;
    logic [IDX_W:0]   instr_vlen;
    logic             rf_rd_en;
    logic [IDX_W-1:0] rf_rd_idx;
    logic [2:0]       alu_out_ctrl;
    logic             alu_addsub;
    logic             alu_mux;
    logic [1:0]       alu_bitwise;
    logic [1:0]       alu_comp;
    logic [WIDTH-1:0] alu_result;
    logic             alu_pred;
    logic             rf_wr_en;
    logic [IDX_W-1:0] rf_wr_idx;
    logic [WIDTH-1:0] rf_wr_data;
    logic             pred_wr_en;
    logic [IDX_W-1:0] pred_wr_idx;
    logic             pred_wr_bit;
    logic             busy;
    logic             done;

    int n_cmp = 0;
    int n_err = 0;

    logic [WIDTH-1:0] exp_val [MAX_VLEN];
    logic             exp_wr  [MAX_VLEN];
    logic [9:0]       exp_ctrl;

    always #5 clk = ~clk;

    alu_vector_sequencer #(.WIDTH(WIDTH), .MAX_VLEN(MAX_VLEN)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instr_out_ctrl (instr_out_ctrl),
        .instr_sub      (instr_sub),
        .instr_use_c    (instr_use_c),
        .instr_bitwise  (instr_bitwise),
        .instr_comp     (instr_comp),
        .instr_is_cmp   (instr_is_cmp),
`ifdef ALU_SEQ_MASK_EN
        .instr_mask     (instr_mask),
`endif
        .instr_vlen     (instr_vlen),
        .rf_rd_en       (rf_rd_en),
        .rf_rd_idx      (rf_rd_idx),
        .alu_out_ctrl   (alu_out_ctrl),
        .alu_addsub     (alu_addsub),
        .alu_mux        (alu_mux),
        .alu_bitwise    (alu_bitwise),
        .alu_comp       (alu_comp),
        .alu_result     (alu_result),
        .alu_pred       (alu_pred),
        .rf_wr_en       (rf_wr_en),
        .rf_wr_idx      (rf_wr_idx),
        .rf_wr_data     (rf_wr_data),
        .pred_wr_en     (pred_wr_en),
        .pred_wr_idx    (pred_wr_idx),
        .pred_wr_bit    (pred_wr_bit),
        .busy           (busy),
        .done           (done)
    );

    // Register file returns operands the cycle after the read, into a combinational ALU.
    logic [IDX_W-1:0] rd_idx_q;
    always_ff @(posedge clk) begin
        if (rf_rd_en) rd_idx_q <= rf_rd_idx;
    end

    logic [WIDTH-1:0] op_a, op_2;
    always_comb begin
        op_a       = WIDTH'(rd_idx_q) + 32'd1;
        op_2       = alu_mux ? 32'd3 : 32'd10;
        alu_result = '0;
        alu_pred   = 1'b0;
        case (alu_out_ctrl)
            3'b000: alu_result = alu_addsub ? op_a - op_2 : op_a + op_2;
            3'b010: alu_result = op_a * op_2;
            3'b100: begin
                case (alu_bitwise)
                    2'd0:    alu_result = op_a & op_2;
                    2'd1:    alu_result = op_a | op_2;
                    2'd2:    alu_result = op_a ^ op_2;
                    default: alu_result = ~op_a;
                endcase
            end
            default: alu_result = '0;
        endcase
        case (alu_comp)
            2'd0:    alu_pred = (op_a == op_2);
            2'd1:    alu_pred = (op_a < op_2);
            2'd2:    alu_pred = (op_a > op_2);
            default: alu_pred = (op_a != op_2);
        endcase
    end

    task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        n_cmp++;
        assert (observed === expected) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic clear_exp();
        for (int i = 0; i < MAX_VLEN; i++) begin
            exp_val[i] = '0;
            exp_wr[i]  = 1'b1;
        end
    endtask

    task automatic drive(input logic [2:0] oc, input logic sub, input logic use_c,
                         input logic [1:0] bw, input logic [1:0] cmp, input logic is_cmp,
                         input logic [IDX_W:0] vl, input logic [MAX_VLEN-1:0] mask);
        instr_out_ctrl = oc;
        instr_sub      = sub;
        instr_use_c    = use_c;
        instr_bitwise  = bw;
        instr_comp     = cmp;
        instr_is_cmp   = is_cmp;
        instr_vlen     = vl;
        instr_mask     = mask;
        instr_valid    = 1'b1;
    endtask

    // Called at a negedge while idle; returns at the negedge of cycle T+1.
    task automatic send(input logic [2:0] oc, input logic sub, input logic use_c,
                        input logic [1:0] bw, input logic [1:0] cmp, input logic is_cmp,
                        input logic [IDX_W:0] vl, input logic [MAX_VLEN-1:0] mask,
                        input logic hold);
        check("ready_before_send", instr_ready, 1);
        drive(oc, sub, use_c, bw, cmp, is_cmp, vl, mask);
        exp_ctrl = {oc, sub, use_c, bw, cmp};
        @(negedge clk);
        if (!hold) instr_valid = 1'b0;
    endtask

    // Walks cycles T+1 .. T+3*vl+1 and ends at the negedge of T+3*vl+2.
    task automatic run_check(input int vl, input logic is_cmp, input int exp_writes);
        int   n_wr;
        int   k;
        int   ph;
        logic in_el;
        logic we;
        n_wr = 0;
        for (int c = 1; c <= 3 * vl + 1; c++) begin
            k     = (c - 1) / 3;
            ph    = (c - 1) % 3;
            in_el = (c <= 3 * vl);
            we    = in_el && (ph == 2) && exp_wr[k];
            check("busy", busy, 1);
            check("ready_low", instr_ready, 0);
            check("done", done, (c == 3 * vl + 1));
            check("alu_ctrl", {alu_out_ctrl, alu_addsub, alu_mux, alu_bitwise, alu_comp}, exp_ctrl);
            check("rd_en", rf_rd_en, in_el && (ph == 0));
            if (in_el && ph == 0) check("rd_idx", rf_rd_idx, k);
            check("rf_wr_en", rf_wr_en, we && !is_cmp);
            check("pred_wr_en", pred_wr_en, we && is_cmp);
            if (rf_wr_en && k < MAX_VLEN) begin
                n_wr++;
                check("wr_idx", rf_wr_idx, k);
                check("wr_data", rf_wr_data, exp_val[k]);
            end
            if (pred_wr_en && k < MAX_VLEN) begin
                n_wr++;
                check("pred_idx", pred_wr_idx, k);
                check("pred_bit", pred_wr_bit, exp_val[k][0]);
            end
            @(negedge clk);
        end
        check("n_writes", n_wr, exp_writes);
        check("idle_ready", instr_ready, 1);
        check("idle_busy", busy, 0);
        check("idle_ctrl", {alu_out_ctrl, alu_addsub, alu_mux, alu_bitwise, alu_comp}, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        drive(3'b000, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0, '0, '1);
        instr_valid = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_ready", instr_ready, 1);
        check("rst_outputs", {rf_rd_en, rf_rd_idx, alu_out_ctrl, alu_addsub, alu_mux, alu_bitwise,
                              alu_comp, rf_wr_en, rf_wr_idx, rf_wr_data, pred_wr_en, pred_wr_idx,
                              pred_wr_bit, busy, done}, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Integer add, vlen=3: 1+10, 2+10, 3+10.
        clear_exp();
        exp_val[0] = 32'd11; exp_val[1] = 32'd12; exp_val[2] = 32'd13;
        send(3'b000, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0, 6'd3, '1, 1'b0);
        run_check(3, 1'b0, 3);

        // Subtract, vlen=2: 1-10, 2-10 wrap.
        clear_exp();
        exp_val[0] = 32'hFFFF_FFF7; exp_val[1] = 32'hFFFF_FFF8;
        send(3'b000, 1'b1, 1'b0, 2'd0, 2'd0, 1'b0, 6'd2, '1, 1'b0);
        run_check(2, 1'b0, 2);

        // Compare A < C (C=3), vlen=4: predicates 1,1,0,0.
        clear_exp();
        exp_val[0] = 32'd1; exp_val[1] = 32'd1; exp_val[2] = 32'd0; exp_val[3] = 32'd0;
        send(3'b000, 1'b0, 1'b1, 2'd0, 2'd1, 1'b1, 6'd4, '1, 1'b0);
        run_check(4, 1'b1, 4);

        // Bitwise xor with C=3, vlen=3: 1^3, 2^3, 3^3.
        clear_exp();
        exp_val[0] = 32'd2; exp_val[1] = 32'd1; exp_val[2] = 32'd0;
        send(3'b100, 1'b0, 1'b1, 2'd2, 2'd0, 1'b0, 6'd3, '1, 1'b0);
        run_check(3, 1'b0, 3);

        // Out-of-range select 101 is still sequenced; zero is written.
        clear_exp();
        exp_val[0] = 32'd0; exp_val[1] = 32'd0;
        send(3'b101, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0, 6'd2, '1, 1'b0);
        run_check(2, 1'b0, 2);

        // vlen=0: done in T+1, no reads, no writes.
        clear_exp();
        send(3'b010, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0, 6'd0, '1, 1'b0);
        run_check(0, 1'b0, 0);

        // vlen=40 clamps to 32 elements: data k+1+10.
        clear_exp();
        for (int i = 0; i < MAX_VLEN; i++) exp_val[i] = 32'(i) + 32'd11;
        send(3'b000, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0, 6'd40, '1, 1'b0);
        run_check(32, 1'b0, 32);

        // Back-to-back: mul vlen=2 (10,20), then add vlen=1 (11) with valid held high.
        clear_exp();
        exp_val[0] = 32'd10; exp_val[1] = 32'd20;
        send(3'b010, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0, 6'd2, '1, 1'b1);
        drive(3'b000, 1'b0, 1'b0, 2'd1, 2'd3, 1'b0, 6'd1, '1);
        run_check(2, 1'b0, 2);
        @(negedge clk);
        instr_valid = 1'b0;
        clear_exp();
        exp_val[0] = 32'd11;
        exp_ctrl    = {3'b000, 1'b0, 1'b0, 2'd1, 2'd3};
        run_check(1, 1'b0, 1);

`ifdef ALU_SEQ_MASK_EN
        // Mask 0101, vlen=4: writes only at idx 0 and 2, done still at T+13.
        clear_exp();
        exp_val[0] = 32'd11; exp_val[2] = 32'd13;
        exp_wr[1]  = 1'b0;   exp_wr[3]  = 1'b0;
        send(3'b000, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0, 6'd4, 32'h0000_0005, 1'b0);
        run_check(4, 1'b0, 2);
`endif

        // Reset during element 1 EX (T+5): its WB at T+6 must never appear.
        clear_exp();
        send(3'b000, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0, 6'd4, '1, 1'b0);
        repeat (4) @(negedge clk);
        check("pre_reset_busy", busy, 1);
        rst_n = 1'b0;
        #1;
        check("async_rst_ready", instr_ready, 1);
        check("async_rst_outputs", {rf_rd_en, rf_rd_idx, alu_out_ctrl, alu_addsub, alu_mux, alu_bitwise,
                                    alu_comp, rf_wr_en, rf_wr_idx, rf_wr_data, pred_wr_en, pred_wr_idx,
                                    pred_wr_bit, busy, done}, 0);
        @(negedge clk);
        check("rst_no_wb", rf_wr_en, 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_ready", instr_ready, 1);
        check("post_rst_busy", busy, 0);
        check("post_rst_wr", rf_wr_en, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/alu_vector_sequencer.md
Name: alu_vector_sequencer

Overview:
- Sequences the shared lane ALU across the elements of one vector instruction.
- Accepts an instruction (ALU control fields plus vector length) over a valid/ready handshake.
- For each element in order, the block:
  - issues a register-file read;
  - holds the ALU controls while the read data passes through the combinational ALU;
  - registers the result;
  - writes the result back, or writes the predicate bit for compares.
- Sits between instruction decode and the ALU/register-file pair of one lane.

Parameters:
- WIDTH, 32, element/data width
- MAX_VLEN, 32, maximum elements per instruction
- IDX_W, $clog2(MAX_VLEN), element index width (derived, not overridden)

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- instr_valid  in  1  instruction offered
- instr_ready  out  1  sequencer idle; accepts when instr_valid && instr_ready
- instr_out_ctrl  in  3  ALU result select (000 addsub, 001 fp add, 010 mul, 011 fp mul, 100 bitwise)
- instr_sub  in  1  0 add, 1 subtract
- instr_use_c  in  1  ALU operand-2 mux: 0 B, 1 C
- instr_bitwise  in  2  bitwise op select
- instr_comp  in  2  compare op select
- instr_is_cmp  in  1  1: write predicate, not data
- instr_vlen  in  IDX_W+1  element count, 0..MAX_VLEN
- rf_rd_en  out  1  read request
- rf_rd_idx  out  IDX_W  element to read; A/B/C return next cycle, straight into the ALU
- alu_out_ctrl / alu_addsub / alu_mux / alu_bitwise / alu_comp  out  3/1/1/2/2  ALU controls
- alu_result  in  WIDTH  ALU finalResult
- alu_pred  in  1  ALU predicate
- rf_wr_en  out  1  data write strobe
- rf_wr_idx  out  IDX_W  write element
- rf_wr_data  out  WIDTH  write data
- pred_wr_en  out  1  predicate write strobe
- pred_wr_idx  out  IDX_W  predicate element
- pred_wr_bit  out  1  predicate value
- busy  out  1  instruction in progress
- done  out  1  one-cycle completion pulse

Behaviour:
- Clock and reset: one clock, clk; rst_n is asynchronous, active-low.
- Reset values: state IDLE, instr_ready=1, every other output 0, element counter 0.
- FSM states: IDLE, RD, EX, WB, DONE.
- IDLE: instr_ready=1. On handshake, latch all instr_* fields. Clamp vlen to MAX_VLEN if larger. Go to RD, or to DONE if vlen==0.
- RD: rf_rd_en=1, rf_rd_idx=idx. Next state EX.
- EX: register alu_result/alu_pred into result regs. Next state WB.
- WB: if !is_cmp, rf_wr_en=1 with idx/data; else pred_wr_en=1 with idx/bit. Then:
  - if idx==vlen-1, go to DONE;
  - otherwise idx++ and go to RD.
- DONE: done=1 for this cycle only, idx cleared, then IDLE.
- ALU control outputs are driven from the latched fields in every non-IDLE state. They are 0 in IDLE and do not change mid-instruction.
- busy=1 in RD/EX/WB/DONE; instr_ready=0 in these states. Decode must hold the next instruction until ready.
- Timing: handshake at cycle T.
  - Element k: RD at T+1+3k, WB at T+3+3k.
  - done at T+3*vlen+1; next accept possible at T+3*vlen+2.
- vlen==0: done at T+1, no reads or writes.
- Out-of-range instr_out_ctrl values (101–111) are accepted and sequenced normally; the ALU returns 0, which is written.
- Exactly one of rf_wr_en/pred_wr_en is set per WB cycle, never both.
- rst_n asserted mid-instruction: immediate return to IDLE. Any WB not yet reached is never issued. Outputs go to reset values asynchronously.

Optional Feature:
- Macro ALU_SEQ_MASK_EN.
- When defined:
  - adds input instr_mask [MAX_VLEN-1:0], latched at accept;
  - elements with mask bit 0 still pass RD/EX/WB with identical timing, but rf_wr_en and pred_wr_en are held 0 in WB.
- When undefined: the port is absent and all elements write.

Decomposition:
- Package alu_seq_pkg holds:
  - the state enum;
  - ALU outputControl constants (ALU_OP_ADDSUB=3'b000, ALU_OP_FPADD, ALU_OP_MUL, ALU_OP_FPMUL, ALU_OP_BITWISE);
  - the packed struct alu_ctrl_t {out_ctrl, addsub, mux, bitwise, comp}.
- One natural sub-module, alu_seq_idx_counter: element counter with clear, increment and last-element compare against vlen.

Test Plan:
1. Reset mid-instruction: vlen=4, rst_n low at T+5 -> all outputs 0 immediately, instr_ready=1 after release, no rf_wr_en at T+6.
2. Integer add, vlen=3, out_ctrl=000, sub=0, A[k]=k+1, B[k]=10 -> rf_wr_en at T+3/T+6/T+9 with data 11,12,13; done at T+10 only.
3. Compare, vlen=4, is_cmp=1 -> pred_wr_en at each WB with pred_wr_bit matching the model; rf_wr_en never 1.
4. vlen=0 -> done at T+1, zero rf_rd_en and zero writes. vlen=40 with MAX_VLEN=32 -> exactly 32 writes, idx 0..31.
5. Back-to-back instructions with instr_valid held high -> second handshake no earlier than T+3*vlen+2; ALU controls switch only after the first done.
6. With ALU_SEQ_MASK_EN, mask=4'b0101, vlen=4 -> writes at idx 0 and 2 only; done still at T+13.
